// File: rtl/button_pkg.sv
// Shared types and default timing constants for the pushbutton conditioner.
package button_pkg;

    // Debounce FSM states
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // 10 ms of stable input at 100 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 1000000;
    // 1 s of held press at 100 MHz
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 100000000;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; q is safe to use in the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton conditioner: synchronizes and debounces a raw button, emits
// press/release strobes and keeps an 8-bit press counter.
// Optional hold detection is built when BUTTON_LONG_PRESS_EN is defined;
// otherwise long_pulse is tied to 0 and no hold counter exists.
//
// state        | meaning
// IDLE         | button accepted as released
// PRESS_WAIT   | input high, waiting for it to stay high long enough
// PRESSED      | button accepted as pressed
// RELEASE_WAIT | input low, waiting for it to stay low long enough
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Parameter sanity checks at elaboration
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
        $error("LONG_PRESS_CYCLES must be at least 1");
    end

    logic             btn_sync;
    state_t           state;
    logic [CNT_W-1:0] deb_cnt;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn),
        .q     (btn_sync)
    );

    // Debounce FSM with registered level, strobes and press counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync) begin
                        state <= IDLE;
                    end else if (deb_cnt == CNT_LAST) begin
                        state       <= PRESSED;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 8'd1;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_sync) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_sync) begin
                        state <= PRESSED;
                    end else if (deb_cnt == CNT_LAST) begin
                        state         <= IDLE;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    // Hold counter saturates one past the firing value so a press fires once,
    // even if a release bounce drops back into PRESSED.
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_PRESS_CYCLES);

    logic              press_accept;
    logic [HOLD_W-1:0] hold_cnt;

    assign press_accept = (state == PRESS_WAIT) && btn_sync && (deb_cnt == CNT_LAST);

    // Hold timer: restart on accepted press, run only in PRESSED, fire once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (press_accept) begin
                hold_cnt <= '0;
            end else if ((state == PRESSED) && (hold_cnt != HOLD_SAT)) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    long_pulse <= 1'b1;
                end
            end
        end
    end
`else
    // Hold detection not built
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10.
module tb_button_conditioner;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn           (btn),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #10 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL reset_level: got %b expected 0", btn_level); end
        checks++;
        if (press_pulse !== 1'b0) begin errors++; $display("FAIL reset_press: got %b expected 0", press_pulse); end
        checks++;
        if (release_pulse !== 1'b0) begin errors++; $display("FAIL reset_release: got %b expected 0", release_pulse); end
        checks++;
        if (long_pulse !== 1'b0) begin errors++; $display("FAIL reset_long: got %b expected 0", long_pulse); end
        checks++;
        if (press_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", press_count); end
    endtask

    task automatic test_bounce();
        int np = 0;
        for (int k = 1; k <= 24; k++) begin
            btn = (k <= 4) ? ((k % 2) == 1) : 1'b0;
            step();
            if (press_pulse) np++;
        end
        checks++;
        if (np !== 0) begin errors++; $display("FAIL bounce_pulses: got %0d expected 0", np); end
        checks++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL bounce_level: got %b expected 0", btn_level); end
        checks++;
        if (press_count !== 8'd0) begin errors++; $display("FAIL bounce_count: got %0d expected 0", press_count); end
    endtask

    task automatic test_clean_press();
        int np = 0, nr = 0, first_p = 0, first_r = 0, overlap = 0;
        btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (press_pulse) begin np++; if (first_p == 0) first_p = k; end
            if (press_pulse && release_pulse) overlap++;
        end
        checks++;
        if (first_p !== 7) begin errors++; $display("FAIL press_latency: got edge %0d expected 7", first_p); end
        checks++;
        if (np !== 1) begin errors++; $display("FAIL press_width: got %0d pulse cycles expected 1", np); end
        checks++;
        if (btn_level !== 1'b1) begin errors++; $display("FAIL press_level: got %b expected 1", btn_level); end
        checks++;
        if (press_count !== 8'd1) begin errors++; $display("FAIL press_count: got %0d expected 1", press_count); end
        btn = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (release_pulse) begin nr++; if (first_r == 0) first_r = k; end
            if (press_pulse && release_pulse) overlap++;
        end
        checks++;
        if (first_r !== 7) begin errors++; $display("FAIL release_latency: got edge %0d expected 7", first_r); end
        checks++;
        if (nr !== 1) begin errors++; $display("FAIL release_width: got %0d pulse cycles expected 1", nr); end
        checks++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL release_level: got %b expected 0", btn_level); end
        checks++;
        if (overlap !== 0) begin errors++; $display("FAIL clean_overlap: got %0d expected 0", overlap); end
    endtask

    task automatic test_release_glitch();
        int nr = 0, np = 0, first_r = 0;
        btn = 1'b1;
        for (int k = 1; k <= 10; k++) step();
        checks++;
        if (btn_level !== 1'b1) begin errors++; $display("FAIL glitch_pressed: got %b expected 1", btn_level); end
        for (int k = 1; k <= 30; k++) begin
            btn = (k == 5);
            step();
            if (release_pulse) begin nr++; if (first_r == 0) first_r = k; end
            if (press_pulse) np++;
        end
        checks++;
        if (first_r !== 12) begin errors++; $display("FAIL glitch_latency: got edge %0d expected 12", first_r); end
        checks++;
        if (nr !== 1) begin errors++; $display("FAIL glitch_release_count: got %0d expected 1", nr); end
        checks++;
        if (np !== 0) begin errors++; $display("FAIL glitch_extra_press: got %0d expected 0", np); end
        checks++;
        if (press_count !== 8'd2) begin errors++; $display("FAIL glitch_count: got %0d expected 2", press_count); end
    endtask

    task automatic test_wrap();
        int np = 0, overlap = 0;
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            btn = 1'b1;
            for (int k = 0; k < 8; k++) begin
                step();
                if (press_pulse) np++;
                if (press_pulse && release_pulse) overlap++;
            end
            btn = 1'b0;
            for (int k = 0; k < 8; k++) begin
                step();
                if (press_pulse && release_pulse) overlap++;
            end
            if (i == 254) begin
                checks++;
                if (press_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", press_count); end
            end
        end
        checks++;
        if (press_count !== 8'd0) begin errors++; $display("FAIL wrap_count: got %0d expected 0", press_count); end
        checks++;
        if (np !== 256) begin errors++; $display("FAIL wrap_pulses: got %0d expected 256", np); end
        checks++;
        if (overlap !== 0) begin errors++; $display("FAIL wrap_overlap: got %0d expected 0", overlap); end
    endtask

    task automatic test_reset_mid();
        int np = 0, nr = 0, first_p = 0;
        btn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (press_pulse) np++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, press_count} !== 12'd0) begin
            errors++;
            $display("FAIL rst_pw_outputs: got lvl=%b p=%b r=%b l=%b cnt=%0d expected all 0",
                     btn_level, press_pulse, release_pulse, long_pulse, press_count);
        end
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (press_pulse) begin np++; if (first_p == 0) first_p = k; end
        end
        checks++;
        if (first_p !== 7) begin errors++; $display("FAIL rst_fresh_debounce: got edge %0d expected 7", first_p); end
        checks++;
        if (np !== 1) begin errors++; $display("FAIL rst_pw_pulses: got %0d expected 1", np); end
        // reset while PRESSED clears the level and count and must not produce a release
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (btn_level !== 1'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_pressed_outputs: got lvl=%b cnt=%0d expected 0 0", btn_level, press_count);
        end
        btn = 1'b0;
        #2 rst_n = 1'b1;
        np = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (press_pulse) np++;
            if (release_pulse) nr++;
        end
        checks++;
        if (np + nr !== 0) begin errors++; $display("FAIL rst_pressed_pulses: got %0d expected 0", np + nr); end
    endtask

    task automatic test_long_press();
        int nl = 0, first_l = 0, first_p = 0;
        int exp_nl, exp_edge;
`ifdef BUTTON_LONG_PRESS_EN
        exp_nl = 1;
        exp_edge = 17;
`else
        exp_nl = 0;
        exp_edge = 0;
`endif
        apply_reset();
        btn = 1'b1;
        for (int k = 1; k <= 37; k++) begin
            step();
            if (press_pulse && first_p == 0) first_p = k;
            if (long_pulse) begin nl++; if (first_l == 0) first_l = k; end
        end
        btn = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (long_pulse) nl++;
        end
        checks++;
        if (first_p !== 7) begin errors++; $display("FAIL long_press_edge: got edge %0d expected 7", first_p); end
        checks++;
        if (nl !== exp_nl) begin errors++; $display("FAIL long_count: got %0d expected %0d", nl, exp_nl); end
        checks++;
        if (first_l !== exp_edge) begin errors++; $display("FAIL long_edge: got edge %0d expected %0d", first_l, exp_edge); end
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 1'b0;
        #23;
        test_reset();
        #4 rst_n = 1'b1;
        test_bounce();
        test_clean_press();
        test_release_glitch();
        test_wrap();
        test_reset_mid();
        test_long_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, sets the stable-input cycles needed to accept a level change (10 ms at 100 MHz); legal range ≥ 1.
REQ-002 Parameter LONG_PRESS_CYCLES, default 100000000, sets the held-press cycles before long_pulse (1 s at 100 MHz); legal range ≥ 1.
REQ-003 clk  input  1  single 100 MHz clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn  input  1  raw asynchronous, bouncing pushbutton; 1 = pressed.
REQ-006 btn_level  output  1  debounced button level.
REQ-007 press_pulse  output  1  one-cycle strobe on accepted press.
REQ-008 release_pulse  output  1  one-cycle strobe on accepted release.
REQ-009 long_pulse  output  1  one-cycle strobe when a press is held LONG_PRESS_CYCLES.
REQ-010 press_count  output  8  count of accepted presses, for LED display.

Function
REQ-011 btn SHALL pass through a 2-flop synchronizer; the FSM SHALL use only its output btn_sync.
REQ-012 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 IDLE: btn_sync=1 -> PRESS_WAIT with debounce counter cleared to 0.
REQ-014 PRESS_WAIT: btn_sync=0 -> IDLE (bounce rejected, no output change); else counter==DEBOUNCE_CYCLES-1 -> PRESSED; else counter+1.
REQ-015 PRESSED: btn_sync=0 -> RELEASE_WAIT with counter cleared.
REQ-016 RELEASE_WAIT: btn_sync=1 -> PRESSED (bounce rejected); else counter==DEBOUNCE_CYCLES-1 -> IDLE; else counter+1.
REQ-017 On the PRESS_WAIT->PRESSED edge: btn_level<=1, press_pulse=1 for exactly one cycle, press_count+1.
REQ-018 On the RELEASE_WAIT->IDLE edge: btn_level<=0, release_pulse=1 for exactly one cycle.
REQ-019 Latency: counting the first edge that samples btn=1 as edge 1, press_pulse SHALL be high in the cycle after edge DEBOUNCE_CYCLES+3. Release latency is identical.
REQ-020 press_count SHALL wrap 255->0 silently.
REQ-021 All outputs SHALL be registered. press_pulse and release_pulse SHALL never be high in the same cycle.
REQ-022 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) bits and SHALL never exceed DEBOUNCE_CYCLES-1.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, clear both synchronizer flops and all counters, and drive btn_level, press_pulse, release_pulse, long_pulse and press_count to 0.
REQ-024 Reset asserted during PRESS_WAIT or PRESSED SHALL produce no pulse. After release of reset with btn held, a fresh full debounce SHALL occur before press_pulse.

Configuration
REQ-025 Macro BUTTON_LONG_PRESS_EN, when defined, SHALL build a hold counter with the following behaviour:
- cleared on PRESS_WAIT->PRESSED;
- increments only while in PRESSED;
- frozen in RELEASE_WAIT;
- fires long_pulse once per press at count LONG_PRESS_CYCLES-1, then saturates.
REQ-026 Without BUTTON_LONG_PRESS_EN, long_pulse SHALL be constant 0 and no hold counter SHALL be synthesized.

Structure
REQ-027 Package button_pkg SHALL hold the FSM state enum and the default cycle constants.
REQ-028 The synchronizer SHALL be sub-module sync2 (1-bit, async active-low reset). All other logic stays in button_conditioner.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10)
REQ-029 Clean press: btn 0->1 held -> press_pulse high one cycle after edge 7, btn_level=1, press_count=1.
REQ-030 Bounce: btn toggles 1,0,1,0 on consecutive edges, then stays 0 -> no press_pulse, btn_level stays 0, press_count stays 0.
REQ-031 Release with one-cycle glitch back to 1 mid-debounce -> release_pulse only after 4 further stable-0 cycles; exactly one release_pulse.
REQ-032 256 clean presses -> press_count reads 0 and exactly 256 press_pulses are seen.
REQ-033 rst_n pulsed low during PRESS_WAIT with btn held -> all outputs 0 immediately; press_pulse 7 cycles after rst_n deasserts.
REQ-034 With BUTTON_LONG_PRESS_EN, hold 30 cycles -> exactly one long_pulse, 10 cycles after press_pulse; without the macro, long_pulse stays 0.
